// File: rtl/snd_dma_addr.sv
// Sound DMA address generator: CPU frame start/end/control registers plus the
// running sound word counter that drives mcucontrol (snd, sft, sndon, sfrep).
module snd_dma_addr #(
  parameter int         AW      = 21,
  parameter logic [1:0] RST_CTL = 2'b00
) (
  input  logic          clk32,
  input  logic          por,
  input  logic          reg_we,
  input  logic [3:0]    reg_sel,
  input  logic [7:0]    reg_din,
  output logic [7:0]    reg_dout,
  input  logic          snd_inc,
  output logic [AW-1:0] snd,
  output logic [AW-1:0] sft,
  output logic          sndon,
  output logic          sfrep,
  output logic          frame_end
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] start_sh, end_sh;
  logic [AW-1:0] cur, cur_nx;
  logic [AW-1:0] act_end, act_end_nx;
  logic [AW-1:0] nxt;
  logic          ctl_on, ctl_on_nx;
  logic          ctl_rep, ctl_rep_nx;
  logic          fe_nx;
  logic          ctl_wr, stop_wr;
  logic [7:0]    rd_byte;

  // Word address bits map onto byte-address lanes: hi=[21:16], mid=[15:8], lo=[7:1]
  function automatic logic [7:0] get_byte(input logic [AW-1:0] w, input logic [1:0] k);
    logic [7:0] b;
    b = '0;
    case (k)
      2'd0:    b[AW-16:0] = w[AW-1:15];
      2'd1:    b          = w[14:7];
      default: b[7:1]     = w[6:0];
    endcase
    return b;
  endfunction

  function automatic logic [AW-1:0] put_byte(input logic [AW-1:0] w, input logic [1:0] k,
                                             input logic [7:0] d);
    logic [AW-1:0] r;
    r = w;
    case (k)
      2'd0:    r[AW-1:15] = d[AW-16:0];
      2'd1:    r[14:7]    = d;
      default: r[6:0]     = d[7:1];
    endcase
    return r;
  endfunction

  assign ctl_wr  = reg_we && (reg_sel == 4'd0);
  assign stop_wr = ctl_wr && !reg_din[0];
  assign nxt     = cur + AW'(1);

  always_comb begin
    rd_byte = '0;
    case (reg_sel)
      4'd0:    rd_byte = {6'b0, ctl_rep, ctl_on};
      4'd1:    rd_byte = get_byte(start_sh, 2'd0);
      4'd2:    rd_byte = get_byte(start_sh, 2'd1);
      4'd3:    rd_byte = get_byte(start_sh, 2'd2);
      4'd4:    rd_byte = get_byte(cur, 2'd0);
      4'd5:    rd_byte = get_byte(cur, 2'd1);
      4'd6:    rd_byte = get_byte(cur, 2'd2);
      4'd7:    rd_byte = get_byte(end_sh, 2'd0);
      4'd8:    rd_byte = get_byte(end_sh, 2'd1);
      4'd9:    rd_byte = get_byte(end_sh, 2'd2);
      default: rd_byte = '0;
    endcase
  end

  // A stop write outranks everything in the FSM, including a coincident snd_inc
  always_comb begin
    state_nx   = state;
    cur_nx     = cur;
    act_end_nx = act_end;
    ctl_on_nx  = ctl_on;
    ctl_rep_nx = ctl_rep;
    fe_nx      = 1'b0;
    if (ctl_wr) begin
      ctl_on_nx  = reg_din[0];
      ctl_rep_nx = reg_din[1];
    end
    if (stop_wr) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (ctl_on) state_nx = LOAD;
        LOAD: begin
          cur_nx     = start_sh;
          act_end_nx = end_sh;
          state_nx   = PLAY;
        end
        PLAY: begin
          if (snd_inc) begin
            if (nxt != act_end) begin
              cur_nx = nxt;
            end else begin
              fe_nx = 1'b1;
              if (ctl_rep) begin
                cur_nx     = start_sh;
                act_end_nx = end_sh;
              end else begin
                cur_nx    = act_end;
                ctl_on_nx = 1'b0;
                state_nx  = IDLE;
              end
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk32) begin
    if (por) begin
      state     <= IDLE;
      cur       <= '0;
      act_end   <= '0;
      start_sh  <= '0;
      end_sh    <= '0;
      ctl_on    <= RST_CTL[0];
      ctl_rep   <= RST_CTL[1];
      frame_end <= 1'b0;
      reg_dout  <= '0;
    end else begin
      state     <= state_nx;
      cur       <= cur_nx;
      act_end   <= act_end_nx;
      ctl_on    <= ctl_on_nx;
      ctl_rep   <= ctl_rep_nx;
      frame_end <= fe_nx;
      reg_dout  <= rd_byte;
      // Shadow writes land at this edge; a reload above already used the old value
      if (reg_we) begin
        case (reg_sel)
          4'd1:    start_sh <= put_byte(start_sh, 2'd0, reg_din);
          4'd2:    start_sh <= put_byte(start_sh, 2'd1, reg_din);
          4'd3:    start_sh <= put_byte(start_sh, 2'd2, reg_din);
          4'd7:    end_sh   <= put_byte(end_sh, 2'd0, reg_din);
          4'd8:    end_sh   <= put_byte(end_sh, 2'd1, reg_din);
          4'd9:    end_sh   <= put_byte(end_sh, 2'd2, reg_din);
          default: ;
        endcase
      end
    end
  end

  assign snd   = cur;
  assign sft   = act_end;
  assign sfrep = ctl_rep;
  assign sndon = (state == PLAY);

endmodule

// File: tb/tb_snd_dma_addr.sv
// Self-checking bench for snd_dma_addr: directed scenarios followed by random
// traffic, all compared against a byte-address level reference model.
module tb_snd_dma_addr;

  localparam int AW   = 21;
  localparam int MASK = (1 << AW) - 1;

  logic          clk32 = 1'b0;
  logic          por, reg_we, snd_inc;
  logic [3:0]    reg_sel;
  logic [7:0]    reg_din, reg_dout;
  logic [AW-1:0] snd, sft;
  logic          sndon, sfrep, frame_end;

  int errors = 0;
  int checks = 0;

  // Reference model state: word addresses as plain ints, mode 0 idle / 1 load / 2 play
  int m_start, m_end, m_cur, m_act, m_mode, m_dout;
  bit m_on, m_rep, m_fe;

  always #5 clk32 = ~clk32;

  snd_dma_addr dut (
    .clk32     (clk32),
    .por       (por),
    .reg_we    (reg_we),
    .reg_sel   (reg_sel),
    .reg_din   (reg_din),
    .reg_dout  (reg_dout),
    .snd_inc   (snd_inc),
    .snd       (snd),
    .sft       (sft),
    .sndon     (sndon),
    .sfrep     (sfrep),
    .frame_end (frame_end)
  );

  function automatic int byte_of(int w, int k);
    int a;
    a = w * 2;
    case (k)
      0:       return (a >> 16) & 'h3F;
      1:       return (a >> 8) & 'hFF;
      default: return a & 'hFE;
    endcase
  endfunction

  function automatic int with_byte(int w, int k, int d);
    int a, sh, mk;
    a = w * 2;
    case (k)
      0:       begin sh = 16; mk = 'h3F0000; end
      1:       begin sh = 8;  mk = 'h00FF00; end
      default: begin sh = 0;  mk = 'h0000FE; end
    endcase
    a = (a & ~mk) | ((d << sh) & mk);
    return (a >> 1) & MASK;
  endfunction

  function automatic int readModel(int sel);
    if (sel == 0) return (int'(m_rep) << 1) | int'(m_on);
    if (sel >= 1 && sel <= 3) return byte_of(m_start, sel - 1);
    if (sel >= 4 && sel <= 6) return byte_of(m_cur, sel - 4);
    if (sel >= 7 && sel <= 9) return byte_of(m_end, sel - 7);
    return 0;
  endfunction

  task automatic modelStep(input logic we, input logic [3:0] sel, input logic [7:0] din,
                           input logic inc, input logic p);
    int n_start, n_end, n_cur, n_act, n_mode, n_dout, nxt, s;
    bit n_on, n_rep, n_fe;
    s = int'(sel);
    if (p) begin
      m_start = 0; m_end = 0; m_cur = 0; m_act = 0; m_mode = 0; m_dout = 0;
      m_on = 0; m_rep = 0; m_fe = 0;
    end else begin
      n_dout = readModel(s);
      n_start = m_start; n_end = m_end; n_cur = m_cur; n_act = m_act;
      n_mode = m_mode; n_on = m_on; n_rep = m_rep; n_fe = 0;
      if (we && s == 0) begin
        n_on  = din[0];
        n_rep = din[1];
      end
      if (we && s == 0 && !din[0]) begin
        n_mode = 0;
      end else if (m_mode == 0) begin
        if (m_on) n_mode = 1;
      end else if (m_mode == 1) begin
        n_cur = m_start; n_act = m_end; n_mode = 2;
      end else if (inc) begin
        nxt = (m_cur + 1) & MASK;
        if (nxt != m_act) n_cur = nxt;
        else begin
          n_fe = 1;
          if (m_rep) begin n_cur = m_start; n_act = m_end; end
          else begin n_cur = m_act; n_on = 0; n_mode = 0; end
        end
      end
      if (we && s >= 1 && s <= 3) n_start = with_byte(m_start, s - 1, int'(din));
      if (we && s >= 7 && s <= 9) n_end = with_byte(m_end, s - 7, int'(din));
      m_start = n_start; m_end = n_end; m_cur = n_cur; m_act = n_act;
      m_mode = n_mode; m_on = n_on; m_rep = n_rep; m_fe = n_fe; m_dout = n_dout;
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("snd", 32'(snd), m_cur);
    checkVal("sft", 32'(sft), m_act);
    checkVal("sndon", 32'(sndon), 32'(m_mode == 2));
    checkVal("sfrep", 32'(sfrep), 32'(m_rep));
    checkVal("frame_end", 32'(frame_end), 32'(m_fe));
    checkVal("reg_dout", 32'(reg_dout), m_dout);
  endtask

  task automatic applyStimulus(input logic we, input logic [3:0] sel, input logic [7:0] din,
                               input logic inc, input logic p);
    reg_we  = we;
    reg_sel = sel;
    reg_din = din;
    snd_inc = inc;
    por     = p;
    modelStep(we, sel, din, inc, p);
    @(posedge clk32);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic inc1();
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic writeAddr(input logic [3:0] base, input int w, input logic rnd_inc);
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b1, base + 4'(k), 8'(byte_of(w, k)),
                    rnd_inc ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
  endtask

  int s, len, e, r;
  logic [3:0] rsel;

  initial begin
    $display("[TB] snd_dma_addr bench start");
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 1'b1);

    // One-shot frame 0x010000..0x010008
    writeAddr(4'd1, 'h08000, 1'b0);
    writeAddr(4'd7, 'h08004, 1'b0);
    applyStimulus(1'b1, 4'd0, 8'h01, 1'b0, 1'b0);
    idle(2);
    checkVal("t2_sndon", 32'(sndon), 1);
    checkVal("t2_snd", 32'(snd), 'h08000);
    checkVal("t2_sft", 32'(sft), 'h08004);
    inc1(); inc1(); inc1();
    checkVal("t2_snd3", 32'(snd), 'h08003);
    inc1();
    checkVal("t2_fe", 32'(frame_end), 1);
    checkVal("t2_end_snd", 32'(snd), 'h08004);
    checkVal("t2_end_sndon", 32'(sndon), 0);
    idle(1);
    checkVal("t2_ctl_read", 32'(reg_dout), 0);

    // Reset held two cycles mid-PLAY
    applyStimulus(1'b1, 4'd0, 8'h01, 1'b0, 1'b0);
    idle(2);
    inc1();
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 1'b1);
    checkVal("t1_snd", 32'(snd), 0);
    checkVal("t1_sndon", 32'(sndon), 0);
    checkVal("t1_fe", 32'(frame_end), 0);

    // Repeat frame, start moved to 0x020000 mid-frame
    writeAddr(4'd1, 'h08000, 1'b0);
    writeAddr(4'd7, 'h08004, 1'b0);
    applyStimulus(1'b1, 4'd0, 8'h03, 1'b0, 1'b0);
    idle(2);
    inc1();
    applyStimulus(1'b1, 4'd1, 8'h02, 1'b0, 1'b0);
    inc1(); inc1(); inc1();
    checkVal("t3_fe", 32'(frame_end), 1);
    checkVal("t3_snd", 32'(snd), 'h10000);
    checkVal("t3_sndon", 32'(sndon), 1);
    applyStimulus(1'b1, 4'd0, 8'h00, 1'b0, 1'b0);

    // Stop write colliding with snd_inc
    applyStimulus(1'b1, 4'd1, 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd0, 8'h01, 1'b0, 1'b0);
    idle(2);
    inc1(); inc1();
    applyStimulus(1'b1, 4'd0, 8'h00, 1'b1, 1'b0);
    checkVal("t4_snd", 32'(snd), 'h08002);
    checkVal("t4_fe", 32'(frame_end), 0);
    checkVal("t4_sndon", 32'(sndon), 0);

    // Wrap through the top of the address space
    writeAddr(4'd1, 'h1FFFFF, 1'b0);
    writeAddr(4'd7, 'h00001, 1'b0);
    applyStimulus(1'b1, 4'd0, 8'h01, 1'b0, 1'b0);
    idle(2);
    checkVal("t5_snd", 32'(snd), 'h1FFFFF);
    inc1();
    checkVal("t5_wrap", 32'(snd), 0);
    inc1();
    checkVal("t5_fe", 32'(frame_end), 1);
    checkVal("t5_snd_end", 32'(snd), 1);
    checkVal("t5_sndon", 32'(sndon), 0);

    // Counter readback and ignored writes
    writeAddr(4'd1, 'h0ABCDE, 1'b0);
    writeAddr(4'd7, 'h0ABD00, 1'b0);
    applyStimulus(1'b1, 4'd0, 8'h01, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b0, 4'd4, 8'h00, 1'b0, 1'b0);
    checkVal("t6_hi", 32'(reg_dout), 'h15);
    applyStimulus(1'b0, 4'd5, 8'h00, 1'b0, 1'b0);
    checkVal("t6_mid", 32'(reg_dout), 'h79);
    applyStimulus(1'b0, 4'd6, 8'h00, 1'b0, 1'b0);
    checkVal("t6_lo", 32'(reg_dout), 'hBC);
    applyStimulus(1'b1, 4'd5, 8'hFF, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd5, 8'h00, 1'b0, 1'b0);
    checkVal("t6_mid_ro", 32'(reg_dout), 'h79);
    applyStimulus(1'b0, 4'd12, 8'h00, 1'b0, 1'b0);
    checkVal("t6_sel12", 32'(reg_dout), 0);
    applyStimulus(1'b1, 4'd0, 8'h00, 1'b0, 1'b0);

    // Random frames with mixed traffic
    for (int f = 0; f < 30; f++) begin
      s   = int'($urandom) & MASK;
      len = int'($urandom_range(1, 10));
      e   = (s + len) & MASK;
      writeAddr(4'd1, s, 1'b1);
      writeAddr(4'd7, e, 1'b1);
      applyStimulus(1'b1, 4'd0, 8'(($urandom_range(0, 1) << 1) | 1), 1'b0, 1'b0);
      for (int c = 0; c < 30; c++) begin
        r    = int'($urandom_range(0, 99));
        rsel = 4'($urandom_range(0, 15));
        if (r < 3)
          applyStimulus(1'b1, 4'd0, 8'($urandom_range(0, 1) << 1), 1'($urandom_range(0, 1)), 1'b0);
        else if (r < 5)
          applyStimulus(1'b1, 4'd0, 8'(($urandom_range(0, 1) << 1) | 1), 1'b0, 1'b0);
        else if (r < 10)
          applyStimulus(1'b1, (rsel == 4'd0) ? 4'd5 : rsel, 8'($urandom_range(0, 255)),
                        1'($urandom_range(0, 1)), 1'b0);
        else if (r < 11)
          applyStimulus(1'b0, rsel, 8'h00, 1'b0, 1'b1);
        else
          applyStimulus(1'b0, rsel, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
